sram_mem_stage_ctrl: RTL

//  Parametrised memory-stage controller between the EX/MEM pipeline register and the 16-bit off-chip SRAM.
//  - Splits one DATA_W-bit load/store into DATA_W/16 sequential SRAM beats, each WAIT_CYC cycles long.
//  - Asserts stall to freeze PC, IF/ID, ID/EX and EX/MEM while the access is in flight.
//  - Successor to the fixed 16-bit, fixed-timing SRAM controller.

---
 rtl/sram_mem_stage_ctrl_if.sv | 27 ++
 rtl/sram_mem_stage_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_stage_ctrl_if
//  Purpose  : Pipeline-side bus between the MEM stage and the SRAM controller.
//  Signals  : rd_en, wr_en   load / store request (driven by the pipeline)
//             addr           word address
//             wr_data        store data
//             rd_data        load data returned by the controller
//             stall          freeze request back to the pipeline
//  Modports : master = pipeline side, slave = controller side
//  Revision : 1.0  initial release
// ============================================================================
interface sram_mem_stage_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              stall;

    modport master (output rd_en, wr_en, addr, wr_data, input  rd_data, stall);
    modport slave  (input  rd_en, wr_en, addr, wr_data, output rd_data, stall);
endinterface
`default_nettype wire

// File: rtl/sram_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_stage_ctrl
//  Purpose  : MEM-stage controller for a 16-bit asynchronous SRAM. Splits one
//             DATA_W-bit load/store into DATA_W/16 beats of WAIT_CYC cycles
//             each and stalls the upstream pipeline while the access runs.
//  Ports    : clk, rst        clock, asynchronous active-high reset
//             bus (slave)     rd_en, wr_en, addr, wr_data -> rd_data, stall
//             SRAM_ADDR       SRAM address (SRAM_AW bits)
//             SRAM_DQ         16-bit bidirectional SRAM data bus
//             SRAM_*_N_O      UB/LB/WE/CE/OE strobes, active-low
//  Options  : WRITE_POST_EN   when defined, stores are posted (no stall for
//                             the accepted write; later requests stall until
//                             the controller is idle again)
//  Revision : 1.0  initial release
// ============================================================================
module sram_mem_stage_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    sram_mem_stage_ctrl_if.slave    bus,
    output logic [SRAM_AW-1:0]      SRAM_ADDR,
    inout  wire  [15:0]             SRAM_DQ,
    output logic                    SRAM_UB_N_O,
    output logic                    SRAM_LB_N_O,
    output logic                    SRAM_WE_N_O,
    output logic                    SRAM_CE_N_O,
    output logic                    SRAM_OE_N_O
);
    localparam int BEATS  = DATA_W / 16;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCNT_W = $clog2(WAIT_CYC);

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);
    localparam logic [WCNT_W-1:0] c_last_wcnt = WCNT_W'(WAIT_CYC - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_done   = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [BEAT_W-1:0] beat_q,    beat_d;
    logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
    logic              op_wr_q,   op_wr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] rbuf_q,    rbuf_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              w_in_access;
    logic              w_last_wait;
    logic              w_req;
    logic              w_stall;
    logic [DATA_W-1:0] w_rbuf_next;

    assign w_in_access = (state_q == c_access);
    assign w_last_wait = (wcnt_q == c_last_wcnt);
    assign w_req       = bus.rd_en | bus.wr_en;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wcnt_d    = wcnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        rd_data_d = rd_data_q;

        // Earlier beats are gathered in a shadow buffer so rd_data only
        // changes once the whole word has arrived.
        w_rbuf_next = rbuf_q;
        w_rbuf_next[int'(beat_q)*16 +: 16] = SRAM_DQ;

        case (state_q)
            c_idle: begin
                if (w_req) begin
                    state_d = c_access;
                    beat_d  = '0;
                    wcnt_d  = '0;
                    op_wr_d = bus.wr_en;   // simultaneous rd/wr resolves to write
                    addr_d  = bus.addr;
                    wdata_d = bus.wr_data;
                end
            end
            c_access: begin
                wcnt_d = wcnt_q + 1'b1;
                if (w_last_wait) begin
                    wcnt_d = '0;
                    if (!op_wr_q) begin
                        rbuf_d = w_rbuf_next;
                    end
                    if (beat_q == c_last_beat) begin
                        if (!op_wr_q) begin
                            rd_data_d = w_rbuf_next;
                        end
`ifdef WRITE_POST_EN
                        // Posted writes retire silently; nothing to hand back.
                        state_d = op_wr_q ? c_idle : c_done;
`else
                        state_d = c_done;
`endif
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            c_done: begin
                // The request visible here belongs to the retiring instruction.
                state_d = c_idle;
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_idle;
            beat_q    <= '0;
            wcnt_q    <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wcnt_q    <= wcnt_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (state_q)
`ifdef WRITE_POST_EN
            c_idle:   w_stall = bus.rd_en & ~bus.wr_en;
            c_access: w_stall = op_wr_q ? w_req : 1'b1;
`else
            c_idle:   w_stall = w_req;
            c_access: w_stall = 1'b1;
`endif
            default:  w_stall = 1'b0;
        endcase
    end

    assign bus.stall   = w_stall;
    assign bus.rd_data = rd_data_q;

    // Truncating addr before the multiply is exact modulo 2**SRAM_AW.
    assign SRAM_ADDR = w_in_access
                     ? (SRAM_AW'(addr_q) * SRAM_AW'(BEATS) + SRAM_AW'(beat_q))
                     : '0;

    // Strobes decode straight from state so an async reset releases them at once.
    assign SRAM_CE_N_O = ~w_in_access;
    assign SRAM_UB_N_O = ~w_in_access;
    assign SRAM_LB_N_O = ~w_in_access;
    assign SRAM_OE_N_O = ~(w_in_access & ~op_wr_q);
    // First and last cycle of each write beat give address/data setup and hold.
    assign SRAM_WE_N_O = ~(w_in_access & op_wr_q & (wcnt_q != '0) & ~w_last_wait);

    assign SRAM_DQ = (w_in_access & op_wr_q) ? wdata_q[int'(beat_q)*16 +: 16] : 16'bz;

endmodule
`default_nettype wire
